array1nr_regx: RTL and testbench



---
 rtl/array_regx_pkg.sv | 30 +++
 rtl/array1nr_rdport.sv | 96 +++++++++
 rtl/array1nr_regx.sv | 125 ++++++++++++
 tb/tb_array1nr_regx.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/array_regx_pkg.sv
//------------------------------------------------------------------------------
// Module : array_regx_pkg
// Brief  : Shared types and configuration helpers for the array1nr_regx RAM.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package array_regx_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int c_MAX_NRD = 8;

  function automatic int nbe_of(input int width, input int bew);
    return width / bew;
  endfunction

  function automatic bit cfg_ok(input int addrbit, input int depth, input int width,
                                input int bew, input int nrd, input int rdlat);
    return (bew > 0) && (width % bew == 0) && (rdlat == 1 || rdlat == 2) &&
           (nrd >= 1) && (nrd <= c_MAX_NRD) && (depth >= 1) &&
           (longint'(depth) <= (longint'(1) << addrbit));
  endfunction

endpackage

`default_nettype wire

// File: rtl/array1nr_rdport.sv
//------------------------------------------------------------------------------
// Module : array1nr_rdport
// Brief  : One read port: range check, write bypass merge, RDLAT-deep pipeline.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module array1nr_rdport
  import array_regx_pkg::*;
#(
  parameter int ADDRBIT = 9,
  parameter int DEPTH   = 512,
  parameter int WIDTH   = 32,
  parameter int BEW     = 8,
  parameter int RDLAT   = 1,
  parameter int BYPASS  = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rdy,
  input  logic                           re,
  input  logic [ADDRBIT-1:0]             ra,
  input  logic [WIDTH-1:0]               word,
  input  logic                           we_acc,
  input  logic [ADDRBIT-1:0]             wa,
  input  logic [nbe_of(WIDTH, BEW)-1:0]  wbe,
  input  logic [WIDTH-1:0]               di,
  output logic [WIDTH-1:0]               dout,
  output logic                           dvld
);

  localparam int               c_NBE   = nbe_of(WIDTH, BEW);
  localparam logic [ADDRBIT:0] c_DEPTH = (ADDRBIT + 1)'(DEPTH);

  logic             w_in_range;
  logic             w_hit;
  logic [WIDTH-1:0] w_merged;
  logic [WIDTH-1:0] w_rdata;
  logic [WIDTH-1:0] r_d1;
  logic             r_v1;

  assign w_in_range = {1'b0, ra} < c_DEPTH;
  assign w_hit      = (BYPASS != 0) && we_acc && (wa == ra);

  always_comb begin
    w_merged = word;
    for (int j = 0; j < c_NBE; j++) begin
      if (w_hit && wbe[j]) begin
        w_merged[j*BEW +: BEW] = di[j*BEW +: BEW];
      end
    end
  end

  // Nothing is readable until the clear sweep has finished.
  assign w_rdata = (rdy && w_in_range) ? w_merged : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_d1 <= '0;
      r_v1 <= 1'b0;
    end else begin
      r_v1 <= re;
      if (re) begin
        r_d1 <= w_rdata;
      end
    end
  end

  generate
    if (RDLAT == 2) begin : g_lat2
      logic [WIDTH-1:0] r_d2;
      logic             r_v2;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_d2 <= '0;
          r_v2 <= 1'b0;
        end else begin
          r_v2 <= r_v1;
          if (r_v1) begin
            r_d2 <= r_d1;
          end
        end
      end

      assign dout = r_d2;
      assign dvld = r_v2;
    end else begin : g_lat1
      assign dout = r_d1;
      assign dvld = r_v1;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/array1nr_regx.sv
//------------------------------------------------------------------------------
// Module : array1nr_regx
// Brief  : One-write / NRD-read register array with byte lanes and clear engine.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module array1nr_regx
  import array_regx_pkg::*;
#(
  parameter int ADDRBIT = 9,
  parameter int DEPTH   = 512,
  parameter int WIDTH   = 32,
  parameter int BEW     = 8,
  parameter int NRD     = 3,
  parameter int RDLAT   = 1,
  parameter int BYPASS  = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clr,
  output logic                           rdy,
  input  logic                           we,
  input  logic [ADDRBIT-1:0]             wa,
  input  logic [nbe_of(WIDTH, BEW)-1:0]  wbe,
  input  logic [WIDTH-1:0]               di,
  input  logic [NRD-1:0]                 re,
  input  logic [NRD*ADDRBIT-1:0]         ra,
  output logic [NRD*WIDTH-1:0]           dout,
  output logic [NRD-1:0]                 dvld
);

  localparam int               c_NBE   = nbe_of(WIDTH, BEW);
  localparam int               c_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDRBIT:0] c_DEPTH = (ADDRBIT + 1)'(DEPTH);
  localparam logic [c_AW-1:0]  c_LAST  = c_AW'(DEPTH - 1);

  generate
    if (!cfg_ok(ADDRBIT, DEPTH, WIDTH, BEW, NRD, RDLAT)) begin : g_cfg_err
      $error("array1nr_regx: unsupported parameter combination");
    end
  endgenerate

  state_t           r_state;
  logic [c_AW-1:0]  r_ptr;
  logic             r_rdy;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_wa_ok;
  logic             w_we_acc;
  logic             w_clr_wr;

  assign rdy      = r_rdy;
  assign w_wa_ok  = {1'b0, wa} < c_DEPTH;
  assign w_we_acc = r_rdy & we & w_wa_ok & ~clr & ~rst;
  assign w_clr_wr = (r_state == ST_INIT) & ~clr & ~rst;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_state <= ST_INIT;
      r_ptr   <= '0;
      r_rdy   <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (r_ptr == c_LAST) begin
            r_state <= ST_RUN;
            r_rdy   <= 1'b1;
            r_ptr   <= '0;
          end else begin
            r_ptr <= r_ptr + c_AW'(1);
          end
        end
        default: r_rdy <= 1'b1;
      endcase
    end
  end

  // Storage has no reset; the sweep above zeroes it one entry per cycle.
  always_ff @(posedge clk) begin
    if (w_clr_wr) begin
      r_mem[r_ptr] <= '0;
    end else if (w_we_acc) begin
      for (int j = 0; j < c_NBE; j++) begin
        if (wbe[j]) begin
          r_mem[wa[c_AW-1:0]][j*BEW +: BEW] <= di[j*BEW +: BEW];
        end
      end
    end
  end

  generate
    for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [ADDRBIT-1:0] w_ra;
      logic [WIDTH-1:0]   w_word;

      assign w_ra   = ra[k*ADDRBIT +: ADDRBIT];
      assign w_word = r_mem[w_ra[c_AW-1:0]];

      array1nr_rdport #(
        .ADDRBIT (ADDRBIT),
        .DEPTH   (DEPTH),
        .WIDTH   (WIDTH),
        .BEW     (BEW),
        .RDLAT   (RDLAT),
        .BYPASS  (BYPASS)
      ) u_rdport (
        .clk    (clk),
        .rst    (rst),
        .rdy    (r_rdy),
        .re     (re[k]),
        .ra     (w_ra),
        .word   (w_word),
        .we_acc (w_we_acc),
        .wa     (wa),
        .wbe    (wbe),
        .di     (di),
        .dout   (dout[k*WIDTH +: WIDTH]),
        .dvld   (dvld[k])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_array1nr_regx.sv
//------------------------------------------------------------------------------
// Module : tb_array1nr_regx
// Brief  : Self-checking bench: latency-1 bypass and latency-2 no-bypass arrays.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_array1nr_regx;

  localparam int c_AB = 10;
  localparam int c_DEPTH = 512;

  logic        clk = 1'b0;
  logic        rst, clr, we;
  logic [9:0]  wa;
  logic [3:0]  wbe;
  logic [31:0] di;
  logic [2:0]  re;
  logic [29:0] ra;
  logic        rdy1, rdy2;
  logic [95:0] dout1, dout2;
  logic [2:0]  dvld1, dvld2;

  always #5 clk = ~clk;

  array1nr_regx #(.ADDRBIT(c_AB), .DEPTH(c_DEPTH), .WIDTH(32), .BEW(8), .NRD(3),
                  .RDLAT(1), .BYPASS(1)) u_dut1 (
    .clk(clk), .rst(rst), .clr(clr), .rdy(rdy1), .we(we), .wa(wa), .wbe(wbe),
    .di(di), .re(re), .ra(ra), .dout(dout1), .dvld(dvld1));

  array1nr_regx #(.ADDRBIT(c_AB), .DEPTH(c_DEPTH), .WIDTH(32), .BEW(8), .NRD(3),
                  .RDLAT(2), .BYPASS(0)) u_dut2 (
    .clk(clk), .rst(rst), .clr(clr), .rdy(rdy2), .we(we), .wa(wa), .wbe(wbe),
    .di(di), .re(re), .ra(ra), .dout(dout2), .dvld(dvld2));

  int checks = 0;
  int failures = 0;

  // Reference model: array contents, remaining clear count, expected outputs.
  logic [31:0] mem_m [c_DEPTH];
  logic        m_rdy = 1'b0;
  int          m_left = c_DEPTH;
  logic [31:0] e1_d [3];
  logic [31:0] e2_d [3];
  logic [31:0] p2_d [3];
  logic        e1_v [3];
  logic        e2_v [3];
  logic        p2_v [3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic model_edge();
    logic        acc;
    logic [31:0] base, byp;
    int          a;
    acc = !rst && !clr && m_rdy && we && (int'(wa) < c_DEPTH);
    for (int k = 0; k < 3; k++) begin
      a = int'(ra[k*10 +: 10]);
      if (m_rdy && a < c_DEPTH) begin
        base = mem_m[a];
        byp  = base;
        if (acc && int'(wa) == a)
          for (int j = 0; j < 4; j++) if (wbe[j]) byp[j*8 +: 8] = di[j*8 +: 8];
      end else begin
        base = 32'h0;
        byp  = 32'h0;
      end
      if (rst) begin
        e1_v[k] = 1'b0; e1_d[k] = 32'h0;
        e2_v[k] = 1'b0; e2_d[k] = 32'h0;
        p2_v[k] = 1'b0;
      end else begin
        e1_v[k] = re[k];
        if (re[k]) e1_d[k] = byp;
        e2_v[k] = p2_v[k];
        if (p2_v[k]) e2_d[k] = p2_d[k];
        p2_v[k] = re[k];
        p2_d[k] = base;
      end
    end
    if (rst || clr) begin
      m_rdy  = 1'b0;
      m_left = c_DEPTH;
    end else if (!m_rdy) begin
      mem_m[c_DEPTH - m_left] = 32'h0;
      m_left--;
      if (m_left == 0) m_rdy = 1'b1;
    end else if (acc) begin
      for (int j = 0; j < 4; j++) if (wbe[j]) mem_m[wa][j*8 +: 8] = di[j*8 +: 8];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("rdy1", 32'(rdy1), 32'(m_rdy));
    chk("rdy2", 32'(rdy2), 32'(m_rdy));
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("dvld1_p%0d", k), 32'(dvld1[k]), 32'(e1_v[k]));
      chk($sformatf("dout1_p%0d", k), dout1[k*32 +: 32], e1_d[k]);
      chk($sformatf("dvld2_p%0d", k), 32'(dvld2[k]), 32'(e2_v[k]));
      chk($sformatf("dout2_p%0d", k), dout2[k*32 +: 32], e2_d[k]);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    we = 1'b0; clr = 1'b0; re = 3'b000;
  endtask

  function automatic logic [9:0] rand_addr();
    if ($urandom_range(0, 9) == 0) return 10'($urandom_range(500, 1023));
    return 10'($urandom_range(0, 15));
  endfunction

  typedef struct {
    logic        we;
    logic [9:0]  wa;
    logic [3:0]  wbe;
    logic [31:0] di;
    logic [2:0]  re;
    logic [29:0] ra;
    logic [95:0] e1;
    logic [95:0] e2;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int n;
    vecs[0] = '{1'b1, 10'd3, 4'hF, 32'h1122_3344, 3'b000, 30'd0, 96'd0, 96'd0};
    vecs[1] = '{1'b1, 10'd3, 4'h5, 32'hAABB_CCDD, 3'b000, 30'd0, 96'd0, 96'd0};
    vecs[2] = '{1'b0, 10'd0, 4'h0, 32'h0, 3'b111, {10'd600, 10'd3, 10'd3},
                {32'h0, 32'h11BB_33DD, 32'h11BB_33DD}, {32'h0, 32'h11BB_33DD, 32'h11BB_33DD}};
    vecs[3] = '{1'b1, 10'd7, 4'hF, 32'h0102_0304, 3'b000, 30'd0, 96'd0, 96'd0};
    vecs[4] = '{1'b1, 10'd7, 4'hC, 32'hDEAD_BEEF, 3'b011, {10'd0, 10'd7, 10'd7},
                {32'h0, 32'hDEAD_0304, 32'hDEAD_0304}, {32'h0, 32'h0102_0304, 32'h0102_0304}};
    vecs[5] = '{1'b0, 10'd0, 4'h0, 32'h0, 3'b001, {10'd0, 10'd0, 10'd7},
                {64'h0, 32'hDEAD_0304}, {64'h0, 32'hDEAD_0304}};
    vecs[6] = '{1'b1, 10'd7, 4'h0, 32'h0, 3'b001, {10'd0, 10'd0, 10'd7},
                {64'h0, 32'hDEAD_0304}, {64'h0, 32'hDEAD_0304}};
    vecs[7] = '{1'b0, 10'd0, 4'h0, 32'h0, 3'b100, {10'd5, 10'd0, 10'd0}, 96'd0, 96'd0};
    vecs[8] = '{1'b1, 10'd600, 4'hF, 32'h1234_5678, 3'b000, 30'd0, 96'd0, 96'd0};
    vecs[9] = '{1'b0, 10'd0, 4'h0, 32'h0, 3'b011, {10'd0, 10'd88, 10'd600}, 96'd0, 96'd0};

    for (int i = 0; i < c_DEPTH; i++) mem_m[i] = 32'h0;
    for (int k = 0; k < 3; k++) begin
      e1_d[k] = 32'h0; e2_d[k] = 32'h0; p2_d[k] = 32'h0;
      e1_v[k] = 1'b0;  e2_v[k] = 1'b0;  p2_v[k] = 1'b0;
    end
    rst = 1'b1; clr = 1'b0; we = 1'b0; wa = '0; wbe = '0; di = '0; re = '0; ra = '0;
    @(negedge clk);
    tick();
    tick();

    // Init sweep length, with a write attempted mid-sweep.
    rst = 1'b0;
    n = 0;
    while (!rdy1 && n < 2000) begin
      if (n == 3) begin
        we = 1'b1; wa = 10'd5; wbe = 4'hF; di = 32'hFFFF_FFFF;
      end else begin
        we = 1'b0;
      end
      tick();
      n++;
    end
    idle();
    chk("init_cycles", 32'(n), 32'(c_DEPTH));

    // Directed vectors: latency-1 result one edge later, latency-2 one edge after that.
    for (int i = 0; i < 10; i++) begin
      we = vecs[i].we; wa = vecs[i].wa; wbe = vecs[i].wbe; di = vecs[i].di;
      re = vecs[i].re; ra = vecs[i].ra;
      tick();
      for (int k = 0; k < 3; k++)
        if (vecs[i].re[k]) chk($sformatf("vec%0d_dut1_p%0d", i, k), dout1[k*32 +: 32], vecs[i].e1[k*32 +: 32]);
      idle();
      tick();
      for (int k = 0; k < 3; k++)
        if (vecs[i].re[k]) chk($sformatf("vec%0d_dut2_p%0d", i, k), dout2[k*32 +: 32], vecs[i].e2[k*32 +: 32]);
    end

    // Back-to-back reads on port 0 of the two-stage array.
    re = 3'b001; ra = {20'd0, 10'd3};
    tick();
    chk("lat2_first_vld", 32'(dvld2[0]), 32'd0);
    chk("lat1_first", dout1[31:0], 32'h11BB_33DD);
    ra = {20'd0, 10'd7};
    tick();
    chk("lat2_b2b_0", dout2[31:0], 32'h11BB_33DD);
    chk("lat2_b2b_0_vld", 32'(dvld2[0]), 32'd1);
    ra = {20'd0, 10'd3};
    tick();
    chk("lat2_b2b_1", dout2[31:0], 32'hDEAD_0304);
    idle();
    tick();
    chk("lat2_b2b_2", dout2[31:0], 32'h11BB_33DD);
    tick();
    chk("lat2_drain_vld", 32'(dvld2[0]), 32'd0);

    // Clear in RUN with a same-cycle read, then a restart mid-sweep.
    clr = 1'b1; re = 3'b001; ra = {20'd0, 10'd3};
    tick();
    chk("clr_preclear", dout1[31:0], 32'h11BB_33DD);
    chk("clr_rdy_drop", 32'(rdy1), 32'd0);
    clr = 1'b0;
    tick();
    chk("clr_read_zero", dout1[31:0], 32'h0);
    idle();
    repeat (100) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n = 0;
    while (!rdy1 && n < 2000) begin
      tick();
      n++;
    end
    chk("clr_restart_cycles", 32'(n), 32'(c_DEPTH));
    re = 3'b011; ra = {10'd0, 10'd7, 10'd3};
    tick();
    idle();
    tick();
    chk("clr_after_3", dout2[31:0], 32'h0);
    chk("clr_after_7", dout2[63:32], 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      we  = 1'($urandom_range(0, 1));
      wa  = rand_addr();
      wbe = 4'($urandom);
      di  = $urandom;
      re  = 3'($urandom);
      for (int k = 0; k < 3; k++)
        ra[k*10 +: 10] = ($urandom_range(0, 2) == 0) ? wa : rand_addr();
      clr = ($urandom_range(0, 599) == 0);
      tick();
    end
    idle();
    tick();

    // Reset with reads in flight.
    re = 3'b111; ra = {10'd7, 10'd3, 10'd3};
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("rst_dvld2", 32'(dvld2), 32'd0);
    chk("rst_dout2", dout2[31:0] | dout2[63:32] | dout2[95:64], 32'h0);
    chk("rst_dvld1", 32'(dvld1), 32'd0);
    rst = 1'b0;
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst_nostale_%0d", i), 32'({dvld2, dvld1}), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
